stack_up_pkt_former: RTL and testbench
======================================

# stack_up_pkt_former

Per-manager stack-bus upstream packet former: accepts a word stream from the PE-array result side, buffers it in a small FIFO, and drives it toward the manager on the stack-bus upstream interface (`stu__mgr__*`) with `cntl` framing generated from packet boundaries. One instance sits directly in front of each manager instance in the manager array, feeding that manager's upstream port. It also enforces a maximum packet length and reports framing statistics to the system.

## Interface

Parameters:
- `DATA_W`, 64: upstream data width.
- `TYPE_W`, 2: upstream type field width.
- `OOB_W`, 32: upstream OOB (tag) width.
- `DEPTH`, 8: FIFO entries; power of two, ≥ 2.
- `MAX_PKT_LEN`, 64: maximum words per packet; range 1..65535.

Ports (clock and reset first):
- `clk`, in, 1: single clock. All logic is on its rising edge.
- `reset_poweron`, in, 1: reset. It is asynchronous and active-high.
- `pe__stu__valid`, in, 1: ingress word valid.
- `pe__stu__data`, in, DATA_W: ingress word.
- `pe__stu__type`, in, TYPE_W: per-word type.
- `pe__stu__oob_data`, in, OOB_W: packet tag. It is sampled only on the first word of a packet.
- `pe__stu__last`, in, 1: marks the final word of a packet.
- `stu__pe__ready`, out, 1: ingress ready.
- `stu__mgr__valid`, out, 1: egress valid.
- `stu__mgr__cntl`, out, 2: framing code. SOM=2'b11, SOP=2'b01, MOP=2'b00, EOP=2'b10.
- `stu__mgr__type`, out, TYPE_W: egress type.
- `stu__mgr__data`, out, DATA_W: egress data.
- `stu__mgr__oob_data`, out, OOB_W: egress tag.
- `mgr__stu__ready`, in, 1: egress ready from the manager.
- `stu__sys__len_err`, out, 1: sticky packet-length error flag.
- `stu__sys__pkt_count`, out, 16: number of packets completed at egress.

## Operation

Ingress:
- A push occurs when `pe__stu__valid && stu__pe__ready`.
- `stu__pe__ready = (count != DEPTH)`. It is combinational from the registered count only.
- Each FIFO entry stores {first, last, type, data, oob}.
- An `in_pkt` flag tracks whether ingress is mid-packet.
  - The first word of a packet is a push with `in_pkt == 0`; on that push the word's `pe__stu__oob_data` is latched into `oob_hold`.
  - Every word of the packet is stored with the oob value captured at its first word.
- A 16-bit word counter counts words pushed in the current packet.
  - If a push is the MAX_PKT_LEN-th word and `pe__stu__last == 0`, the stored `last` bit is forced to 1 and `stu__sys__len_err` is set. The error flag is sticky until reset.
  - The next pushed word then starts a new packet with a fresh oob capture.
- On a push with `last == 1` (stored value), `in_pkt` and the word counter are cleared.

Egress:
- `stu__mgr__valid = (count != 0)`. The head entry drives `data`, `type` and `oob_data` directly.
- `cntl` is derived from the head entry: first&&last gives SOM, first gives SOP, last gives EOP, otherwise MOP.
- A pop occurs when `stu__mgr__valid && mgr__stu__ready`.
- A pop of an entry with `last == 1` increments `stu__sys__pkt_count`, which wraps from 0xFFFF to 0.

Simultaneous and boundary events:
- Simultaneous push and pop: count is unchanged and both pointers advance.
- When the FIFO is full, a push is blocked (no pass-through), even if a pop occurs in the same cycle.
- Pointers are log2(DEPTH) bits and wrap naturally. Count is log2(DEPTH)+1 bits.

Reset (asynchronous assert, any time, including mid-packet):
- Clears pointers, count, `in_pkt`, the word counter, `oob_hold`, `len_err` and `pkt_count`.
- Partially buffered packets are discarded.

## Timing

- Reset values of outputs:
  - `stu__mgr__valid` = 0, `stu__mgr__cntl` = 2'b00, data/type/oob = 0 (head storage is cleared on reset).
  - `stu__pe__ready` = 1, `stu__sys__len_err` = 0, `stu__sys__pkt_count` = 0.
- Latency: a word pushed at edge N is presented at egress after edge N, i.e. valid in cycle N+1 when the FIFO was empty.
- Throughput: one word per cycle sustained when the manager holds ready=1.
- `stu__mgr__*` outputs stay stable while `valid && !ready` (head unchanged).
- `len_err` and `pkt_count` update on the edge of the causing push or pop respectively.

## Test plan

- **Reset:** assert `reset_poweron` mid-packet with 5 words buffered → next cycle valid=0, ready=1, pkt_count=0. A new packet then starts with SOP/SOM framing.
- **Single-word packet:** push data=0xA5, last=1, oob=0x1234, manager ready=1 → next cycle valid=1, cntl=SOM, oob=0x1234. pkt_count becomes 1 after the pop.
- **4-word packet:** oob on word0 is 0xBEEF, words 1-3 carry oob 0 → egress cntl sequence SOP, MOP, MOP, EOP, all with oob=0xBEEF.
- **Backpressure and full:** mgr ready=0, push 9 words with DEPTH=8 → ready deasserts after the 8th push and the 9th word is held. Raise mgr ready → all words emerge in order with no loss or duplication. A simultaneous push and pop while full is still blocked.
- **Length limit:** MAX_PKT_LEN=4, push a 6-word packet → egress framing SOP, MOP, MOP, EOP, SOP, EOP. len_err=1 and stays 1. pkt_count increments by 2.
- **Counter wrap:** preload activity of 65536 single-word packets → pkt_count wraps to 0 with no side effects.

Source files
------------

// File: rtl/stack_up_pkt_former_if.sv
// rtl/stack_up_pkt_former_if.sv - PE-side ingress and manager-side egress stream bundle
interface stack_up_pkt_former_if #(
    parameter int DATA_W = 64,
    parameter int TYPE_W = 2,
    parameter int OOB_W  = 32
);
    logic              pe__stu__valid;
    logic [DATA_W-1:0] pe__stu__data;
    logic [TYPE_W-1:0] pe__stu__type;
    logic [OOB_W-1:0]  pe__stu__oob_data;
    logic              pe__stu__last;
    logic              stu__pe__ready;

    logic              stu__mgr__valid;
    logic [1:0]        stu__mgr__cntl;
    logic [TYPE_W-1:0] stu__mgr__type;
    logic [DATA_W-1:0] stu__mgr__data;
    logic [OOB_W-1:0]  stu__mgr__oob_data;
    logic              mgr__stu__ready;

    modport master (
        output pe__stu__valid, pe__stu__data, pe__stu__type, pe__stu__oob_data, pe__stu__last,
        output mgr__stu__ready,
        input  stu__pe__ready,
        input  stu__mgr__valid, stu__mgr__cntl, stu__mgr__type, stu__mgr__data, stu__mgr__oob_data
    );

    modport slave (
        input  pe__stu__valid, pe__stu__data, pe__stu__type, pe__stu__oob_data, pe__stu__last,
        input  mgr__stu__ready,
        output stu__pe__ready,
        output stu__mgr__valid, stu__mgr__cntl, stu__mgr__type, stu__mgr__data, stu__mgr__oob_data
    );
endinterface

// File: rtl/stack_up_pkt_former.sv
// rtl/stack_up_pkt_former.sv - upstream packet former: FIFO with cntl framing, length limit and stats
module stack_up_pkt_former #(
    parameter int DATA_W      = 64,
    parameter int TYPE_W      = 2,
    parameter int OOB_W       = 32,
    parameter int DEPTH       = 8,
    parameter int MAX_PKT_LEN = 64
) (
    input  logic                 clk,
    input  logic                 reset_poweron,
    stack_up_pkt_former_if.slave bus,
    output logic                 stu__sys__len_err,
    output logic [15:0]          stu__sys__pkt_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] CNTL_SOM = 2'b11;
    localparam logic [1:0] CNTL_SOP = 2'b01;
    localparam logic [1:0] CNTL_MOP = 2'b00;
    localparam logic [1:0] CNTL_EOP = 2'b10;

    logic [DATA_W-1:0] mem_data  [DEPTH];
    logic [TYPE_W-1:0] mem_type  [DEPTH];
    logic [OOB_W-1:0]  mem_oob   [DEPTH];
    logic              mem_first [DEPTH];
    logic              mem_last  [DEPTH];

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             in_pkt;
    logic [15:0]      word_cnt;
    logic [OOB_W-1:0] oob_hold;

    logic             push;
    logic             pop;
    logic             is_first;
    logic             at_max;
    logic             store_last;
    logic [OOB_W-1:0] store_oob;

    assign bus.stu__pe__ready  = (count != CW'(DEPTH));
    assign bus.stu__mgr__valid = (count != '0);

    assign push = bus.pe__stu__valid && bus.stu__pe__ready;
    assign pop  = bus.stu__mgr__valid && bus.mgr__stu__ready;

    // The tag is live on the first word only; later words reuse the held copy.
    assign is_first   = !in_pkt;
    assign store_oob  = is_first ? bus.pe__stu__oob_data : oob_hold;
    assign at_max     = (word_cnt == 16'(MAX_PKT_LEN - 1));
    assign store_last = bus.pe__stu__last || at_max;

    assign bus.stu__mgr__data     = mem_data[rd_ptr];
    assign bus.stu__mgr__type     = mem_type[rd_ptr];
    assign bus.stu__mgr__oob_data = mem_oob[rd_ptr];

    always_comb begin
        bus.stu__mgr__cntl = CNTL_MOP;
        if (mem_first[rd_ptr] && mem_last[rd_ptr]) begin
            bus.stu__mgr__cntl = CNTL_SOM;
        end else if (mem_first[rd_ptr]) begin
            bus.stu__mgr__cntl = CNTL_SOP;
        end else if (mem_last[rd_ptr]) begin
            bus.stu__mgr__cntl = CNTL_EOP;
        end
    end

    always_ff @(posedge clk or posedge reset_poweron) begin
        if (reset_poweron) begin
            wr_ptr              <= '0;
            rd_ptr              <= '0;
            count               <= '0;
            in_pkt              <= 1'b0;
            word_cnt            <= '0;
            oob_hold            <= '0;
            stu__sys__len_err   <= 1'b0;
            stu__sys__pkt_count <= '0;
            // Storage is cleared so the idle head presents all-zero fields.
            for (int i = 0; i < DEPTH; i++) begin
                mem_data[i]  <= '0;
                mem_type[i]  <= '0;
                mem_oob[i]   <= '0;
                mem_first[i] <= 1'b0;
                mem_last[i]  <= 1'b0;
            end
        end else begin
            if (push) begin
                mem_data[wr_ptr]  <= bus.pe__stu__data;
                mem_type[wr_ptr]  <= bus.pe__stu__type;
                mem_oob[wr_ptr]   <= store_oob;
                mem_first[wr_ptr] <= is_first;
                mem_last[wr_ptr]  <= store_last;
                wr_ptr            <= wr_ptr + 1'b1;
                if (is_first) begin
                    oob_hold <= bus.pe__stu__oob_data;
                end
                if (store_last) begin
                    in_pkt   <= 1'b0;
                    word_cnt <= '0;
                end else begin
                    in_pkt   <= 1'b1;
                    word_cnt <= word_cnt + 16'd1;
                end
                if (at_max && !bus.pe__stu__last) begin
                    stu__sys__len_err <= 1'b1;
                end
            end

            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                if (mem_last[rd_ptr]) begin
                    stu__sys__pkt_count <= stu__sys__pkt_count + 16'd1;
                end
            end

            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_stack_up_pkt_former.sv
// tb/tb_stack_up_pkt_former.sv - directed scoreboard bench for stack_up_pkt_former
module tb_stack_up_pkt_former;
    localparam logic [1:0] SOM = 2'b11;
    localparam logic [1:0] SOP = 2'b01;
    localparam logic [1:0] MOP = 2'b00;
    localparam logic [1:0] EOP = 2'b10;

    logic        clk;
    logic        reset_poweron;
    logic        len_err;
    logic [15:0] pkt_count;

    int tests;
    int fails;

    logic [99:0] sb [$];

    stack_up_pkt_former_if #(.DATA_W(64), .TYPE_W(2), .OOB_W(32)) bus ();

    stack_up_pkt_former #(
        .DATA_W(64), .TYPE_W(2), .OOB_W(32), .DEPTH(8), .MAX_PKT_LEN(4)
    ) dut (
        .clk                 (clk),
        .reset_poweron       (reset_poweron),
        .bus                 (bus.slave),
        .stu__sys__len_err   (len_err),
        .stu__sys__pkt_count (pkt_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Egress monitor: every accepted word is compared with the oldest expectation.
    always @(negedge clk) begin
        if (reset_poweron === 1'b0 && bus.stu__mgr__valid === 1'b1 && bus.mgr__stu__ready === 1'b1) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $error("FAIL egress_extra: observed cntl %0h data %0h expected no word",
                       bus.stu__mgr__cntl, bus.stu__mgr__data);
            end else begin
                chk("egress", 128'({bus.stu__mgr__cntl, bus.stu__mgr__type,
                                   bus.stu__mgr__data, bus.stu__mgr__oob_data}),
                    128'(sb.pop_front()));
            end
        end
    end

    task automatic push(input logic [63:0] d, input logic [1:0] t, input logic [31:0] o,
                        input logic l, input logic [1:0] ec, input logic [31:0] eo);
        int n;
        bus.pe__stu__valid    = 1'b1;
        bus.pe__stu__data     = d;
        bus.pe__stu__type     = t;
        bus.pe__stu__oob_data = o;
        bus.pe__stu__last     = l;
        n = 0;
        forever begin
            @(negedge clk);
            if (bus.stu__pe__ready === 1'b1) break;
            n++;
            if (n > 200) begin
                chk("push_timeout", 128'(n), 128'(0));
                break;
            end
        end
        if (n <= 200) sb.push_back({ec, t, d, eo});
        @(posedge clk);
        #1;
        bus.pe__stu__valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) chk("drain_timeout", 128'(sb.size()), 128'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed simulation still running expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tests = 0;
        fails = 0;
        reset_poweron         = 1'b1;
        bus.pe__stu__valid    = 1'b0;
        bus.pe__stu__data     = '0;
        bus.pe__stu__type     = '0;
        bus.pe__stu__oob_data = '0;
        bus.pe__stu__last     = 1'b0;
        bus.mgr__stu__ready   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 128'(bus.stu__mgr__valid), 128'(0));
        chk("rst_ready", 128'(bus.stu__pe__ready), 128'(1));
        chk("rst_head", 128'({bus.stu__mgr__cntl, bus.stu__mgr__type,
                              bus.stu__mgr__data, bus.stu__mgr__oob_data}), 128'(0));
        chk("rst_len_err", 128'(len_err), 128'(0));
        chk("rst_pkt_count", 128'(pkt_count), 128'(0));
        reset_poweron = 1'b0;
        @(posedge clk);
        #1;

        // Single-word packet, one-cycle latency
        bus.mgr__stu__ready = 1'b1;
        push(64'hA5, 2'd1, 32'h1234, 1'b1, SOM, 32'h1234);
        chk("som_valid", 128'(bus.stu__mgr__valid), 128'(1));
        chk("som_head", 128'({bus.stu__mgr__cntl, bus.stu__mgr__data, bus.stu__mgr__oob_data}),
            128'({SOM, 64'hA5, 32'h1234}));
        drain();
        chk("som_pkt_count", 128'(pkt_count), 128'(1));

        // Four-word packet exactly at the length limit
        push(64'h10, 2'd2, 32'hBEEF, 1'b0, SOP, 32'hBEEF);
        push(64'h11, 2'd2, 32'h0,    1'b0, MOP, 32'hBEEF);
        push(64'h12, 2'd2, 32'h0,    1'b0, MOP, 32'hBEEF);
        push(64'h13, 2'd3, 32'h0,    1'b1, EOP, 32'hBEEF);
        drain();
        chk("max_exact_len_err", 128'(len_err), 128'(0));
        chk("pkt4_pkt_count", 128'(pkt_count), 128'(2));

        // Backpressure until full, then push against a full FIFO while popping
        bus.mgr__stu__ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            push(64'h100 + 64'(i), 2'(i), 32'hA000 + 32'(i), i[0],
                 i[0] ? EOP : SOP, 32'hA000 + 32'(i & ~1));
        end
        chk("full_ready", 128'(bus.stu__pe__ready), 128'(0));
        repeat (3) @(posedge clk);
        #1;
        chk("stall_head", 128'({bus.stu__mgr__valid, bus.stu__mgr__cntl, bus.stu__mgr__data,
                                bus.stu__mgr__oob_data}), 128'({1'b1, SOP, 64'h100, 32'hA000}));
        bus.mgr__stu__ready = 1'b1;
        fork
            push(64'h108, 2'd0, 32'hA008, 1'b1, SOM, 32'hA008);
            begin
                @(posedge clk);
                #1;
                bus.mgr__stu__ready = 1'b0;
                chk("full_push_blocked", 128'(bus.stu__pe__ready), 128'(1));
            end
        join
        chk("refull_ready", 128'(bus.stu__pe__ready), 128'(0));
        bus.mgr__stu__ready = 1'b1;
        drain();
        chk("bp_pkt_count", 128'(pkt_count), 128'(7));

        // Six-word packet split by the length limit, fresh tag on the split
        chk("pre_len_err", 128'(len_err), 128'(0));
        push(64'h20, 2'd1, 32'h11, 1'b0, SOP, 32'h11);
        push(64'h21, 2'd1, 32'h22, 1'b0, MOP, 32'h11);
        push(64'h22, 2'd1, 32'h33, 1'b0, MOP, 32'h11);
        chk("len_err_before_limit", 128'(len_err), 128'(0));
        push(64'h23, 2'd1, 32'h44, 1'b0, EOP, 32'h11);
        chk("len_err_set", 128'(len_err), 128'(1));
        push(64'h24, 2'd1, 32'h55, 1'b0, SOP, 32'h55);
        push(64'h25, 2'd1, 32'h66, 1'b1, EOP, 32'h55);
        drain();
        chk("split_pkt_count", 128'(pkt_count), 128'(9));

        // Reset with five words buffered, two of them an open packet
        bus.mgr__stu__ready = 1'b0;
        push(64'h30, 2'd0, 32'h99, 1'b0, SOP, 32'h99);
        push(64'h31, 2'd0, 32'h0,  1'b0, MOP, 32'h99);
        push(64'h32, 2'd0, 32'h0,  1'b1, EOP, 32'h99);
        push(64'h33, 2'd0, 32'h88, 1'b0, SOP, 32'h88);
        push(64'h34, 2'd0, 32'h0,  1'b0, MOP, 32'h88);
        chk("len_err_sticky", 128'(len_err), 128'(1));
        #2;
        reset_poweron = 1'b1;
        #1;
        sb.delete();
        chk("async_rst_valid", 128'(bus.stu__mgr__valid), 128'(0));
        chk("async_rst_ready", 128'(bus.stu__pe__ready), 128'(1));
        chk("async_rst_stats", 128'({len_err, pkt_count}), 128'(0));
        @(posedge clk);
        #1;
        reset_poweron = 1'b0;
        bus.mgr__stu__ready = 1'b1;
        push(64'h40, 2'd2, 32'h77, 1'b0, SOP, 32'h77);
        push(64'h41, 2'd2, 32'h0,  1'b1, EOP, 32'h77);
        drain();
        chk("post_rst_pkt_count", 128'(pkt_count), 128'(1));

        // Statistics counter wrap at full throughput
        for (int i = 0; i < 65535; i++) begin
            push(64'(i), 2'(i), 32'(i), 1'b1, SOM, 32'(i));
        end
        drain();
        chk("wrap_pkt_count", 128'(pkt_count), 128'(0));
        chk("wrap_side_effects", 128'({len_err, bus.stu__mgr__valid, bus.stu__pe__ready}),
            128'({1'b0, 1'b0, 1'b1}));
        push(64'h55, 2'd1, 32'h5555, 1'b1, SOM, 32'h5555);
        drain();
        chk("after_wrap_pkt_count", 128'(pkt_count), 128'(1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
